// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for the execute stage.
// One bit per cycle: shift-add multiply, restoring divide. Results held in
// Hi/Lo until the next accepted operation.
// Optional build macro MULDIV_EARLY_TERM_EN: multiply leaves RUN as soon as
// the remaining multiplier bits are all zero.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             Abort,
  output logic             Busy,
  output logic             Valid,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             DivByZero
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             neg_q, neg_d;      // product / quotient needs negation
  logic             sgna_q, sgna_d;    // dividend sign, applied to remainder
  logic             divz_q, divz_d;    // operation in flight is a divide by zero
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2:0]      acc_q, acc_d;      // mult: product; div: {remainder, dividend/quotient}
  logic [W2-1:0]    a_q, a_d;          // mult: shifted multiplicand; div: divisor in low half
  logic [WIDTH-1:0] b_q, b_d;          // mult: remaining multiplier; div-by-zero: raw SrcA
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;

  logic             sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH+1:0] diff;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic             done;

  // Operand sign extraction and magnitudes (unsigned ops pass through raw)
  always_comb begin
    sa    = ~Op[0] & SrcA[WIDTH-1];
    sb    = ~Op[0] & SrcB[WIDTH-1];
    mag_a = sa ? ('0 - SrcA) : SrcA;
    mag_b = sb ? ('0 - SrcB) : SrcB;
  end

  // Datapath helpers: restoring-divide trial subtract and sign correction
  always_comb begin
    r_sh     = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    diff     = {1'b0, r_sh} - {2'b00, a_q[WIDTH-1:0]};
    prod_fix = neg_q  ? ('0 - acc_q[W2-1:0])        : acc_q[W2-1:0];
    quo_fix  = neg_q  ? ('0 - acc_q[WIDTH-1:0])     : acc_q[WIDTH-1:0];
    rem_fix  = sgna_q ? ('0 - acc_q[W2-1:WIDTH])    : acc_q[W2-1:WIDTH];
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    sgna_d  = sgna_q;
    divz_d  = divz_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start && !Abort) begin
          op_d    = Op;
          neg_d   = sa ^ sb;
          sgna_d  = sa;
          cnt_d   = CW'(WIDTH);
          valid_d = 1'b0;
          if (Op[1] && (SrcB == '0)) begin
            divz_d  = 1'b1;
            b_d     = SrcA;
            state_d = S_FIX;
          end else begin
            divz_d  = 1'b0;
            state_d = S_RUN;
            if (Op[1]) begin
              acc_d = {{(WIDTH+1){1'b0}}, mag_a};
              a_d   = {{WIDTH{1'b0}}, mag_b};
            end else begin
              acc_d = '0;
              a_d   = {{WIDTH{1'b0}}, mag_a};
              b_d   = mag_b;
            end
          end
        end
      end

      S_RUN: begin
        if (Abort) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
          done  = (cnt_q == CW'(1));
          if (op_q[1]) begin
            if (!diff[WIDTH+1]) acc_d = {diff[WIDTH:0], acc_q[WIDTH-2:0], 1'b1};
            else                acc_d = {r_sh, acc_q[WIDTH-2:0], 1'b0};
          end else begin
            if (b_q[0]) acc_d = acc_q + {1'b0, a_q};
            a_d = a_q << 1;
            b_d = b_q >> 1;
`ifdef MULDIV_EARLY_TERM_EN
            if ((b_q >> 1) == '0) done = 1'b1;
`endif
          end
          if (done) state_d = S_FIX;
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        if (Abort) begin
          valid_d = 1'b0;
        end else begin
          valid_d = 1'b1;
          dbz_d   = divz_q;
          if (divz_q) begin
            hi_d = b_q;
            lo_d = '1;
          end else if (op_q[1]) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[W2-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      neg_q   <= 1'b0;
      sgna_q  <= 1'b0;
      divz_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      sgna_q  <= sgna_d;
      divz_q  <= divz_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  // The stored flag is masked while busy so an abort restores the old value
  always_comb begin
    Busy      = (state_q != S_IDLE);
    Valid     = valid_q;
    Hi        = hi_q;
    Lo        = lo_q;
    DivByZero = dbz_q & ~Busy;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32).
module tb_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Rst, Start, Abort;
  logic [1:0]  Op;
  logic [31:0] SrcA, SrcB;
  logic        Busy, Valid, DivByZero;
  logic [31:0] Hi, Lo;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MULDIV_EARLY_TERM_EN
  localparam int LAT_5X3 = 4;
  localparam int LAT_9X0 = 3;
  localparam int LAT_6X7 = 5;
`else
  localparam int LAT_5X3 = 34;
  localparam int LAT_9X0 = 34;
  localparam int LAT_6X7 = 34;
`endif

  muldiv_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
    .Abort(Abort), .Busy(Busy), .Valid(Valid), .Hi(Hi), .Lo(Lo),
    .DivByZero(DivByZero)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present an operation; returns #1 after the edge that samples Start
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    Op = op; SrcA = a; SrcB = b; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  // Counts edges from the Start-sampling edge until Valid; flags Busy gaps
  task automatic wait_valid(output int edges, output int gaps);
    edges = 1;
    gaps  = 0;
    while (!Valid && edges < 200) begin
      if (!Busy) gaps++;
      @(posedge Clk); #1;
      edges++;
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk); #1;
    end
  endtask

  int e, g;

  initial begin
    Rst = 1'b1; Start = 1'b0; Abort = 1'b0; Op = 2'b00; SrcA = '0; SrcB = '0;
    step(2);
    @(negedge Clk); Rst = 1'b0;
    #1;
    check("reset_flags", {61'd0, Busy, Valid, DivByZero}, 64'd0);
    check("reset_hilo",  {Hi, Lo}, 64'd0);

    // MULT -3 * 5
    start_op(2'b00, 32'hFFFF_FFFD, 32'd5);
    check("mult_busy_start", {62'd0, Busy, Valid}, 64'd2);
    wait_valid(e, g);
    check("mult_latency", 64'(e), 64'd34);
    check("mult_busy_gap", 64'(g), 64'd0);
    check("mult_hilo", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFF1);

    // MULTU max*max, then back-to-back DIVU 100/7 on the Valid cycle
    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_valid(e, g);
    check("multu_latency", 64'(e), 64'd34);
    check("multu_hilo", {Hi, Lo}, 64'hFFFF_FFFE_0000_0001);
    start_op(2'b11, 32'd100, 32'd7);
    check("b2b_valid_drop", {62'd0, Busy, Valid}, 64'd2);
    check("b2b_hilo_held", {Hi, Lo}, 64'hFFFF_FFFE_0000_0001);
    wait_valid(e, g);
    check("divu_latency", 64'(e), 64'd34);
    check("divu_hilo", {Hi, Lo}, {32'd2, 32'd14});

    // DIV -7 / 2
    start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_valid(e, g);
    check("div_neg_hilo", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    // DIV most-negative / -1
    start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_valid(e, g);
    check("div_ovf_hilo", {Hi, Lo}, 64'h0000_0000_8000_0000);

    // DIVU 100 / 0
    start_op(2'b11, 32'd100, 32'd0);
    wait_valid(e, g);
    check("dbz_latency", 64'(e), 64'd2);
    check("dbz_hilo", {Hi, Lo}, 64'h0000_0064_FFFF_FFFF);
    check("dbz_flag", {63'd0, DivByZero}, 64'd1);

    // MULTU 6*7; the new Start clears DivByZero
    start_op(2'b01, 32'd6, 32'd7);
    check("dbz_cleared", {63'd0, DivByZero}, 64'd0);
    wait_valid(e, g);
    check("multu67_latency", 64'(e), 64'(LAT_6X7));
    check("multu67_hilo", {Hi, Lo}, 64'd42);

    // MULT aborted at RUN cycle 10
    start_op(2'b00, 32'd3, 32'h4000_0000);
    step(9);
    Abort = 1'b1;
    @(posedge Clk); #1;
    Abort = 1'b0;
    check("abort_flags", {61'd0, Busy, Valid, DivByZero}, 64'd0);
    check("abort_hilo", {Hi, Lo}, 64'd42);

    // Abort and Start together in IDLE: Start dropped
    @(negedge Clk);
    Op = 2'b01; SrcA = 32'd1; SrcB = 32'd1; Start = 1'b1; Abort = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0; Abort = 1'b0;
    check("idle_abort_start", {62'd0, Busy, Valid}, 64'd0);

    // Reset at RUN cycle 5
    start_op(2'b00, 32'd3, 32'h4000_0000);
    step(4);
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    check("rst_mid_flags", {61'd0, Busy, Valid, DivByZero}, 64'd0);
    check("rst_mid_hilo", {Hi, Lo}, 64'd0);

    // Early-termination candidates
    start_op(2'b01, 32'd5, 32'd3);
    wait_valid(e, g);
    check("multu53_latency", 64'(e), 64'(LAT_5X3));
    check("multu53_lo", {32'd0, Lo}, 64'd15);
    start_op(2'b01, 32'd9, 32'd0);
    wait_valid(e, g);
    check("multu90_latency", 64'(e), 64'(LAT_9X0));
    check("multu90_hilo", {Hi, Lo}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit for the execute stage; successor to the fixed 32-bit signed/unsigned multiplier.
- Adds a data width parameter, signed and unsigned divide, an abort input for squashed instructions, and a divide-by-zero flag.
- Results are held in internal HI/LO registers until the next accepted operation, so the external product register is no longer needed.

Parameters:
WIDTH, 32, operand width; Hi/Lo are each WIDTH bits; must be >= 4.

Ports:
Clk  input  1  clock; all logic updates on the rising edge.
Rst  input  1  synchronous, active-high reset.
Start  input  1  begin an operation; sampled only in IDLE.
Op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
SrcA  input  WIDTH  multiplicand or dividend.
SrcB  input  WIDTH  multiplier or divisor.
Abort  input  1  cancel the operation in flight (squashed instruction).
Busy  output  1  operation in progress.
Valid  output  1  Hi/Lo hold the result of the last accepted operation.
Hi  output  WIDTH  multiply: upper product half; divide: remainder.
Lo  output  WIDTH  multiply: lower product half; divide: quotient.
DivByZero  output  1  last completed divide had SrcB == 0.

Behaviour:
- Reset: state IDLE; Busy=0, Valid=0, Hi=0, Lo=0, DivByZero=0. Applies mid-operation and has priority over every other input.
- States: IDLE, RUN, FIX.
- IDLE to RUN on Start && !Abort:
  - latch Op, sign flags and magnitudes (|x| for signed ops, raw for unsigned);
  - clear Valid and DivByZero;
  - set Busy; load iteration counter with WIDTH.
- Divide with SrcB == 0 goes IDLE to FIX instead. FIX then writes Hi=SrcA as latched, Lo=all ones, DivByZero=1.
- RUN, one bit per cycle:
  - multiply uses shift-add: LSB of the remaining multiplier selects an add of the multiplicand into the 2*WIDTH accumulator, then shift;
  - divide uses restoring shift-subtract;
  - counter decrements each cycle; at 0, go to FIX.
- FIX (1 cycle): apply sign correction and write Hi/Lo, then go to IDLE with Busy=0 and Valid=1.
  - MULT: negate the 2*WIDTH product if signA^signB.
  - DIV: quotient negated if signA^signB; remainder takes the sign of the dividend.
- Latency: Valid rises WIDTH+2 rising edges after the edge that samples Start (34 for WIDTH=32). Divide by zero takes 2 edges.
- Signed overflow, most negative value / -1: Lo=most negative value, Hi=0. This falls out of modulo-2^WIDTH negation; no special case.
- Valid and Hi/Lo hold until the next accepted Start. Valid drops on the edge that accepts Start; Hi/Lo keep their old values until FIX.
- Start while Busy is ignored.
- Abort in RUN or FIX: next edge goes to IDLE with Busy=0, Valid=0; Hi/Lo/DivByZero keep their pre-Start values.
- Abort in IDLE: no effect, including a Start in the same cycle.
- Abort and Start together in IDLE: Abort wins and Start is dropped.
- Arithmetic: accumulator 2*WIDTH+1 bits to absorb the carry; all negation is two's complement modulo 2^WIDTH.

Optional Feature:
MULDIV_EARLY_TERM_EN:
- Defined: for multiply only, RUN exits to FIX after the first iteration that leaves the remaining multiplier bits all zero. RUN length becomes max(1, bit length of |SrcB|).
- Undefined: RUN always lasts WIDTH cycles.
- Divide timing is unchanged in both builds.

Test Plan:
- WIDTH=32, MULT SrcA=0xFFFFFFFD (-3), SrcB=5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1; Valid rises 34 edges after Start; Busy high in between.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001. Back-to-back Start on the cycle Valid rises -> Valid drops next edge, new result 34 edges later.
- DIV -7/2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0. DIVU 100/7 -> Lo=14, Hi=2.
- DIVU 100/0 -> Valid after 2 edges, Hi=0x00000064, Lo=0xFFFFFFFF, DivByZero=1. Next Start clears DivByZero.
- MULTU 6*7 completes (Lo=42), then a new MULT with Abort at RUN cycle 10 -> Busy=0, Valid=0 next edge, Hi=0, Lo=42. Rst at RUN cycle 5 -> all outputs 0 next edge.
- With MULDIV_EARLY_TERM_EN: MULTU 5*3 -> Lo=15, Valid after 4 edges; MULTU 9*0 -> Lo=0 after 3 edges. Without the macro both take 34 edges.
